booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Booth multiplier core (CU+DP pair, 8-bit multiplicand, 4-bit multiplier, 9-bit product) between NREQ requesters. It accepts one operand pair per grant and issues a single-cycle start to the core. It waits for core completion, with a watchdog timeout, and returns the product to the granted requester over a valid/ready response handshake. It sits between the requesting client blocks and the multiplier core top level.

---
 rtl/booth_mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one Booth multiplier core between NREQ requesters.
// Accept -> start pulse -> wait for done (watchdog abort) -> valid/ready response to the granted requester.
module booth_mul_arbiter #(
  parameter int NREQ    = 2,
  parameter int MCW     = 8,
  parameter int MPW     = 4,
  parameter int PW      = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*MCW-1:0]  req_mcand,
  input  logic [NREQ*MPW-1:0]  req_mplier,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [PW-1:0]        resp_product,
  output logic                 resp_timeout,
  output logic                 core_start,
  output logic                 core_abort,
  output logic [MCW-1:0]       core_mcand,
  output logic [MPW-1:0]       core_mplier,
  input  logic                 core_done,
  input  logic [PW-1:0]        core_product,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [MCW-1:0] mcand_q, mcand_d;
  logic [MPW-1:0] mplier_q, mplier_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic           tout_q, tout_d;

  logic           win_vld;
  logic [IW-1:0]  win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [MCW-1:0] mcand_sel;
  logic [MPW-1:0] mplier_sel;
  logic           rdy_sel;
  logic           deadline;
  int             cand;

  // Rotating priority search starting at rr_ptr, plus winner operand mux.
  always_comb begin
    win_vld    = 1'b0;
    win_idx    = '0;
    cand       = 0;
    win_onehot = '0;
    mcand_sel  = '0;
    mplier_sel = '0;
    rdy_sel    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!win_vld && cand == i && req_valid[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      win_onehot[i] = win_vld && (win_idx == IW'(i));
      if (win_idx == IW'(i)) begin
        mcand_sel  = req_mcand[i*MCW +: MCW];
        mplier_sel = req_mplier[i*MPW +: MPW];
      end
      if (gnt_q == IW'(i)) rdy_sel = resp_ready[i];
    end
  end

  assign deadline = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    timer_d  = timer_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    tout_d   = tout_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          mcand_d  = mcand_sel;
          mplier_d = mplier_sel;
          gnt_d    = win_idx;
          rr_ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A done on the deadline cycle still delivers the real product.
        if (core_done) begin
          prod_d  = core_product;
          tout_d  = 1'b0;
          state_d = S_RESP;
        end else if (deadline) begin
          prod_d  = '0;
          tout_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rdy_sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      timer_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      timer_q  <= timer_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = (state_q == S_RESP) && (gnt_q == IW'(i));
    end
  end

  assign req_ready    = (state_q == S_IDLE) ? win_onehot : '0;
  assign core_start   = (state_q == S_ISSUE);
  assign core_abort   = (state_q == S_WAIT) && deadline && !core_done;
  assign core_mcand   = mcand_q;
  assign core_mplier  = mplier_q;
  assign resp_product = prod_q;
  assign resp_timeout = tout_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed requests, scoreboard of expected responses, behavioural core model.
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [15:0] req_mcand;
  logic [7:0]  req_mplier;
  logic [8:0]  resp_product, core_product;
  logic        resp_timeout, core_start, core_abort, core_done, busy;
  logic [7:0]  core_mcand;
  logic [3:0]  core_mplier;

  logic        model_done = 1'b0;
  logic        spur_done;
  int          core_lat;
  int          cm_cnt = -1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [8:0] prod;
    logic       to;
  } exp_t;
  exp_t sb[$];

  booth_mul_arbiter #(.NREQ(2), .MCW(8), .MPW(4), .PW(9), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mcand(req_mcand), .req_mplier(req_mplier),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_timeout(resp_timeout),
    .core_start(core_start), .core_abort(core_abort),
    .core_mcand(core_mcand), .core_mplier(core_mplier),
    .core_done(core_done), .core_product(core_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: done pulse core_lat cycles after start (0 = never).
  assign core_done    = model_done | spur_done;
  assign core_product = 9'(int'(core_mcand) * int'(core_mplier));

  always @(negedge clk) begin
    if (rst) cm_cnt = -1;
    else if (core_start) cm_cnt = (core_lat > 0) ? core_lat : -1;
    else if (cm_cnt >= 0) cm_cnt = cm_cnt - 1;
    model_done = (cm_cnt == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && (resp_valid & resp_ready) != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got valid %b product %0d, expected none", resp_valid, resp_product);
      end else begin
        e = sb.pop_front();
        chk("resp_idx", 32'(resp_valid), 32'(1) << e.idx);
        chk("resp_product", 32'(resp_product), 32'(e.prod));
        chk("resp_timeout", 32'(resp_timeout), 32'(e.to));
      end
    end
  end

  task automatic grant(input int i, input logic [7:0] mc, input logic [3:0] mp);
    int n;
    @(negedge clk);
    req_mcand[i*8 +: 8] = mc;
    req_mplier[i*4 +: 4] = mp;
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready_grant", 32'(req_ready), 32'(1) << i);
    @(negedge clk);
    req_valid[i] = 1'b0;
    #1;
    chk("core_start", 32'(core_start), 32'd1);
    chk("core_operands", {20'd0, core_mcand, core_mplier}, {20'd0, mc, mp});
  endtask

  // Counts cycles from the ISSUE cycle until resp_valid rises.
  task automatic wait_resp(output int n, output int ab, output logic allbusy);
    n = 0;
    ab = -1;
    allbusy = busy;
    while (resp_valid == 2'b00 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (core_abort && ab < 0) ab = n;
      if (!busy) allbusy = 1'b0;
    end
  endtask

  initial begin
    int n, ab;
    logic allbusy, seen;
    int gidx[4];
    int gcyc[4];
    int g;

    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_mcand = '0;
    req_mplier = '0;
    spur_done = 1'b0;
    core_lat = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {3'd0, req_ready, resp_valid, resp_product, resp_timeout, core_start,
        core_abort, core_mcand, core_mplier, busy}, 32'd0);
    rst = 1'b0;

    // Single request: 5*3, core done 4 cycles after start.
    resp_ready = 2'b11;
    core_lat = 4;
    sb.push_back('{0, 9'd15, 1'b0});
    grant(0, 8'd5, 4'd3);
    wait_resp(n, ab, allbusy);
    chk("single_latency", n, 5);
    chk("single_busy", 32'(allbusy), 32'd1);
    @(negedge clk);
    #1;
    chk("single_idle_after", {30'd0, busy, resp_valid[0]}, 32'd0);

    // Fairness from a fresh reset (rr_ptr back to 0), minimum spacing with done after one cycle.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_mcand = {8'd4, 8'd3};
    req_mplier = {4'd5, 4'd2};
    core_lat = 1;
    req_valid = 2'b11;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gidx[g] = req_ready[1] ? 1 : 0;
        gcyc[g] = c;
        if (req_ready[1]) sb.push_back('{1, 9'd20, 1'b0});
        else sb.push_back('{0, 9'd6, 1'b0});
        g++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("fair_grants", g, 4);
    chk("fair_g0", gidx[0], 0);
    chk("fair_g1", gidx[1], 1);
    chk("fair_g2", gidx[2], 0);
    chk("fair_g3", gidx[3], 1);
    for (int k = 0; k < 3; k++) chk("fair_spacing", gcyc[k+1] - gcyc[k], 4);
    repeat (8) @(negedge clk);

    // Response backpressure: requester 0 holds resp_ready low for 5 cycles, requester 1 waits.
    resp_ready = 2'b10;
    core_lat = 3;
    sb.push_back('{0, 9'd18, 1'b0});
    grant(0, 8'd9, 4'd2);
    wait_resp(n, ab, allbusy);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("bp_hold", {19'd0, resp_valid, resp_product, resp_timeout, req_ready, core_start},
          {19'd0, 2'b01, 9'd18, 1'b0, 2'b00, 1'b0});
    end
    @(negedge clk);
    req_valid = 2'b00;
    resp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("bp_idle_after", {30'd0, busy, |resp_valid}, 32'd0);

    // Watchdog: core never answers.
    resp_ready = 2'b10;
    core_lat = 0;
    sb.push_back('{1, 9'd0, 1'b1});
    grant(1, 8'd20, 4'd3);
    wait_resp(n, ab, allbusy);
    chk("timeout_abort_cycle", ab, 16);
    chk("timeout_resp_cycle", n, 17);
    chk("timeout_abort_single", 32'(core_abort), 32'd0);
    @(negedge clk);
    @(negedge clk);
    spur_done = 1'b1;
    #1;
    chk("late_done_busy", {30'd0, busy, core_start}, 32'd0);
    @(negedge clk);
    spur_done = 1'b0;
    #1;
    chk("late_done_ignored", {29'd0, busy, resp_valid}, 32'd0);

    // Done on the deadline cycle: product wins, no abort.
    resp_ready = 2'b01;
    core_lat = 16;
    sb.push_back('{0, 9'd12, 1'b0});
    grant(0, 8'd6, 4'd2);
    wait_resp(n, ab, allbusy);
    chk("deadline_no_abort", ab, -1);
    chk("deadline_resp_cycle", n, 17);
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT.
    resp_ready = 2'b11;
    core_lat = 0;
    grant(1, 8'd7, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {3'd0, req_ready, resp_valid, resp_product, resp_timeout, core_start,
        core_abort, core_mcand, core_mplier, busy}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid != 2'b00 || busy) seen = 1'b1;
    end
    chk("midreset_silent", 32'(seen), 32'd0);
    core_lat = 2;
    req_valid = 2'b11;
    #1;
    chk("midreset_rrptr", 32'(req_ready), 32'd1);
    sb.push_back('{0, 9'd12, 1'b0});
    @(negedge clk);
    req_valid = 2'b00;
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
